// File: rtl/read_info_router.sv
// rtl/read_info_router.sv - read-request descriptor queue and per-beat channel steering
// Optional counters built when READ_INFO_STATS_EN is defined.
module read_info_router #(
  parameter int NUM_PU        = 1,
  parameter int NUM_DTYPES    = 2,
  parameter int D_TYPE_W      = 2,
  parameter int RD_SIZE_W     = 20,
  parameter int RD_INFO_DEPTH = 8,
  localparam int PU_ID_W      = $clog2(NUM_PU) + 1
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     rd_req,
  input  logic [RD_SIZE_W-1:0]     rd_req_size,
  input  logic [PU_ID_W-1:0]       rd_req_pu_id,
  input  logic [D_TYPE_W-1:0]      rd_req_d_type,
  output logic                     read_info_full,
  input  logic                     inbuf_empty,
  output logic                     inbuf_pop,
  output logic [NUM_DTYPES-1:0]    out_push,
  input  logic [NUM_DTYPES-1:0]    out_full,
  output logic [PU_ID_W-1:0]       out_pu_id,
  output logic [D_TYPE_W-1:0]      out_d_type,
  output logic                     busy,
  output logic [1:0]               err,
  output logic [31:0]              stat_reqs,
  output logic [NUM_DTYPES*32-1:0] stat_beats
);

  localparam int PTR_W  = $clog2(RD_INFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int DESC_W = RD_SIZE_W + PU_ID_W + D_TYPE_W;

  typedef enum logic {S_IDLE, S_ACTIVE} state_t;

  state_t               state;
  logic [DESC_W-1:0]    mem [RD_INFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr, rd_ptr;
  logic [CNT_W-1:0]     count;
  logic [RD_SIZE_W-1:0] remaining;
  logic [RD_SIZE_W-1:0] head_size;
  logic [PU_ID_W-1:0]   head_pu_id;
  logic [D_TYPE_W-1:0]  head_d_type;
  logic                 enq, deq, last_beat, bad_dtype, head_bad, sel_full;

  assign {head_size, head_pu_id, head_d_type} = mem[rd_ptr];

  assign read_info_full = (count == CNT_W'(RD_INFO_DEPTH));
  assign enq       = rd_req && !read_info_full && (rd_req_size != '0);
  assign bad_dtype = (32'(out_d_type) >= 32'(NUM_DTYPES));
  assign head_bad  = (32'(head_d_type) >= 32'(NUM_DTYPES));
  assign busy      = (state == S_ACTIVE) || (count != '0);

  always_comb begin
    sel_full = 1'b0;
    out_push = '0;
    for (int c = 0; c < NUM_DTYPES; c++) begin
      if (out_d_type == D_TYPE_W'(c)) sel_full = out_full[c];
    end
    inbuf_pop = (state == S_ACTIVE) && !inbuf_empty && (bad_dtype || !sel_full);
    for (int c = 0; c < NUM_DTYPES; c++) begin
      if (out_d_type == D_TYPE_W'(c)) out_push[c] = inbuf_pop && !bad_dtype;
    end
  end

  assign last_beat = inbuf_pop && (remaining == RD_SIZE_W'(1));
  // The next head loads on the edge that retires the last beat, so descriptors run back to back.
  assign deq = (count != '0) && ((state == S_IDLE) || last_beat);

  always_ff @(posedge clk) begin
    if (enq) mem[wr_ptr] <= {rd_req_size, rd_req_pu_id, rd_req_d_type};
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (enq) wr_ptr <= wr_ptr + PTR_W'(1);
      if (deq) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({enq, deq})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= S_IDLE;
      remaining  <= '0;
      out_pu_id  <= '0;
      out_d_type <= '0;
      err        <= 2'b00;
    end else begin
      if (rd_req && read_info_full) err[0] <= 1'b1;
      if (deq) begin
        state      <= S_ACTIVE;
        remaining  <= head_size;
        out_pu_id  <= head_pu_id;
        out_d_type <= head_d_type;
        if (head_bad) err[1] <= 1'b1;
      end else if (last_beat) begin
        state      <= S_IDLE;
        remaining  <= '0;
        out_pu_id  <= '0;
        out_d_type <= '0;
      end else if (inbuf_pop) begin
        remaining <= remaining - RD_SIZE_W'(1);
      end
    end
  end

`ifdef READ_INFO_STATS_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      stat_reqs  <= '0;
      stat_beats <= '0;
    end else begin
      if (enq) stat_reqs <= stat_reqs + 32'd1;
      for (int c = 0; c < NUM_DTYPES; c++) begin
        if (out_push[c]) stat_beats[c*32 +: 32] <= stat_beats[c*32 +: 32] + 32'd1;
      end
    end
  end
`else
  assign stat_reqs  = '0;
  assign stat_beats = '0;
`endif

endmodule

// File: tb/tb_read_info_router.sv
// tb/tb_read_info_router.sv - directed vector table plus corner sequences for read_info_router
module tb_read_info_router;

  logic        clk, resetn;
  logic        rd_req;
  logic [19:0] rd_req_size;
  logic [0:0]  rd_req_pu_id;
  logic [1:0]  rd_req_d_type;
  logic        read_info_full;
  logic        inbuf_empty;
  logic        inbuf_pop;
  logic [1:0]  out_push;
  logic [1:0]  out_full;
  logic [0:0]  out_pu_id;
  logic [1:0]  out_d_type;
  logic        busy;
  logic [1:0]  err;
  logic [31:0] stat_reqs;
  logic [63:0] stat_beats;

  read_info_router dut (
    .clk(clk), .resetn(resetn), .rd_req(rd_req), .rd_req_size(rd_req_size),
    .rd_req_pu_id(rd_req_pu_id), .rd_req_d_type(rd_req_d_type),
    .read_info_full(read_info_full), .inbuf_empty(inbuf_empty), .inbuf_pop(inbuf_pop),
    .out_push(out_push), .out_full(out_full), .out_pu_id(out_pu_id),
    .out_d_type(out_d_type), .busy(busy), .err(err),
    .stat_reqs(stat_reqs), .stat_beats(stat_beats)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int rst, req, size, dt, empty, ofull;
    int pop, push, busy, err;
  } vec_t;

  vec_t vt[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   t2_end;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic v(input int rst, req, size, dt, empty, ofull, pop, push, bsy, er);
    vt.push_back('{rst, req, size, dt, empty, ofull, pop, push, bsy, er});
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    rd_req = 1'b0; rd_req_size = '0; rd_req_pu_id = '0; rd_req_d_type = '0;
    inbuf_empty = 1'b0; out_full = '0;
    @(posedge clk); #1;
    resetn = 1'b1;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  initial begin
    int e_r, e_b0, e_b1;
    int got0, got1, exp_b[2], viol, left, cyc;

    resetn = 1'b0;
    rd_req = 1'b0; rd_req_size = '0; rd_req_pu_id = '0; rd_req_d_type = '0;
    inbuf_empty = 1'b1; out_full = '0;
    #3;
    chk("reset pop",   64'(inbuf_pop), 64'(0));
    chk("reset push",  64'(out_push), 64'(0));
    chk("reset busy",  64'(busy), 64'(0));
    chk("reset full",  64'(read_info_full), 64'(0));
    chk("reset err",   64'(err), 64'(0));
    chk("reset ids",   64'({out_pu_id, out_d_type}), 64'(0));
    chk("reset stats", 64'(stat_reqs) | stat_beats, 64'(0));

    // single size-3 request on channel 1: first pop two cycles after rd_req
    v(1, 1, 3, 1, 0, 0,  0, 0, 0, 0);
    v(0, 0, 0, 0, 0, 0,  0, 0, 1, 0);
    v(0, 0, 0, 0, 0, 0,  1, 2, 1, 0);
    v(0, 0, 0, 0, 0, 0,  1, 2, 1, 0);
    v(0, 0, 0, 0, 0, 0,  1, 2, 1, 0);
    v(0, 0, 0, 0, 0, 0,  0, 0, 0, 0);
    // back-to-back descriptors, no bubble
    v(1, 1, 2, 0, 0, 0,  0, 0, 0, 0);
    v(0, 1, 1, 1, 0, 0,  0, 0, 1, 0);
    v(0, 0, 0, 0, 0, 0,  1, 1, 1, 0);
    v(0, 0, 0, 0, 0, 0,  1, 1, 1, 0);
    v(0, 0, 0, 0, 0, 0,  1, 2, 1, 0);
    v(0, 0, 0, 0, 0, 0,  0, 0, 0, 0);
    t2_end = vt.size() - 1;
    // bad d_type: popped and dropped, err[1] from the load edge
    v(1, 1, 4, 3, 0, 0,  0, 0, 0, 0);
    v(0, 0, 0, 0, 0, 0,  0, 0, 1, 0);
    v(0, 0, 0, 0, 0, 0,  1, 0, 1, 2);
    v(0, 0, 0, 0, 0, 1,  1, 0, 1, 2);
    v(0, 0, 0, 0, 0, 0,  1, 0, 1, 2);
    v(0, 0, 0, 0, 0, 0,  1, 0, 1, 2);
    v(0, 0, 0, 0, 0, 0,  0, 0, 0, 2);
    // stalls: own channel full, other channel full, input empty, zero-size ignored
    v(1, 1, 2, 0, 0, 0,  0, 0, 0, 0);
    v(0, 1, 0, 1, 0, 0,  0, 0, 1, 0);
    v(0, 0, 0, 0, 0, 1,  0, 0, 1, 0);
    v(0, 0, 0, 0, 0, 2,  1, 1, 1, 0);
    v(0, 0, 0, 0, 1, 0,  0, 0, 1, 0);
    v(0, 0, 0, 0, 0, 0,  1, 1, 1, 0);
    v(0, 0, 0, 0, 0, 0,  0, 0, 0, 0);

    step();
    for (int i = 0; i < vt.size(); i++) begin
      if (vt[i].rst != 0) do_reset();
      rd_req        = 1'(vt[i].req);
      rd_req_size   = 20'(vt[i].size);
      rd_req_d_type = 2'(vt[i].dt);
      inbuf_empty   = 1'(vt[i].empty);
      out_full      = 2'(vt[i].ofull);
      #4;
      chk($sformatf("row%0d pop", i),  64'(inbuf_pop), 64'(vt[i].pop));
      chk($sformatf("row%0d push", i), 64'(out_push),  64'(vt[i].push));
      chk($sformatf("row%0d busy", i), 64'(busy),      64'(vt[i].busy));
      chk($sformatf("row%0d err", i),  64'(err),       64'(vt[i].err));
      if (i == t2_end) begin
`ifdef READ_INFO_STATS_EN
        e_r = 2; e_b0 = 2; e_b1 = 1;
`else
        e_r = 0; e_b0 = 0; e_b1 = 0;
`endif
        chk("stat_reqs",   64'(stat_reqs),          64'(e_r));
        chk("stat_beats0", 64'(stat_beats[31:0]),   64'(e_b0));
        chk("stat_beats1", 64'(stat_beats[63:32]),  64'(e_b1));
      end
      step();
    end

    // fill: one descriptor goes active, eight queue, the tenth is dropped
    do_reset();
    inbuf_empty = 1'b1;
    for (int i = 0; i < 9; i++) begin
      rd_req = 1'b1; rd_req_size = 20'd1; rd_req_d_type = 2'(i % 2);
      #4;
      chk($sformatf("fill%0d full", i), 64'(read_info_full), 64'(0));
      step();
    end
    rd_req_d_type = 2'd0;
    #4;
    chk("full after 9", 64'(read_info_full), 64'(1));
    chk("err before drop", 64'(err), 64'(0));
    step();
    rd_req = 1'b0;
    #4;
    chk("err after drop", 64'(err), 64'(1));
    step();
    inbuf_empty = 1'b0;
    got0 = 0; got1 = 0; cyc = 0;
    while (busy && cyc < 100) begin
      #4;
      got0 += int'(out_push[0]); got1 += int'(out_push[1]);
      step(); cyc++;
    end
    chk("drain done", 64'(busy), 64'(0));
    chk("drain ch0", 64'(got0), 64'(5));
    chk("drain ch1", 64'(got1), 64'(4));

    // reset mid-request drops pop/push at once
    do_reset();
    rd_req = 1'b1; rd_req_size = 20'd4; rd_req_d_type = 2'd3;
    step();
    rd_req = 1'b0;
    step();
    #4;
    chk("pre-reset pop", 64'(inbuf_pop), 64'(1));
    chk("pre-reset dtype", 64'(out_d_type), 64'(3));
    resetn = 1'b0;
    #1;
    chk("async pop",  64'(inbuf_pop), 64'(0));
    chk("async push", 64'(out_push), 64'(0));
    chk("async err",  64'(err), 64'(0));
    chk("async busy", 64'(busy), 64'(0));
    step();
    resetn = 1'b1;

    // random backpressure soak
    do_reset();
    exp_b[0] = 0; exp_b[1] = 0; got0 = 0; got1 = 0; viol = 0; left = 1000; cyc = 0;
    while ((left > 0 || busy) && cyc < 60000) begin
      rd_req = 1'b0;
      if (left > 0 && !read_info_full && $urandom_range(0, 1) == 1) begin
        rd_req = 1'b1;
        rd_req_size = 20'($urandom_range(1, 10));
        rd_req_d_type = 2'($urandom_range(0, 1));
        exp_b[rd_req_d_type[0]] += int'(rd_req_size);
        left--;
      end
      inbuf_empty = ($urandom_range(0, 3) == 0);
      out_full = {($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0)};
      #4;
      if ((out_push & out_full) != 2'b00) viol++;
      got0 += int'(out_push[0]); got1 += int'(out_push[1]);
      step(); cyc++;
    end
    chk("soak finished", 64'(cyc < 60000), 64'(1));
    chk("soak ch0 beats", 64'(got0), 64'(exp_b[0]));
    chk("soak ch1 beats", 64'(got1), 64'(exp_b[1]));
    chk("soak push while full", 64'(viol), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
